register_file_sb: RTL and testbench

Parametrised integer register file with an integrated per-register pending-write scoreboard, for the decode stage.
- Next generation of the 2-read/1-write decode register file: configurable data width, register count and read-port count.
- Multi-bit saturating pending counters, a pipeline flush, and x0 hardwired to zero.
- Raises a combinational stall toward fetch/decode on read-after-write hazards; delivers registered operands to execute.

---
 rtl/register_file_sb.sv | 125 ++++++++++++
 tb/tb_register_file_sb.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_sb.sv
// register_file_sb: decode-stage integer register file with a per-register pending-write scoreboard.
// Optional WB_BYPASS_EN: a read waiting only on the final outstanding write-back takes wb_data_i directly.
module register_file_sb #(
  parameter  int XLEN         = 32,
  parameter  int NUM_REGS     = 32,
  parameter  int NUM_RD_PORTS = 2,
  parameter  int PEND_W       = 2,
  localparam int AW           = $clog2(NUM_REGS)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_RD_PORTS-1:0]      rd_en_i,
  input  logic [NUM_RD_PORTS*AW-1:0]   rd_addr_i,
  output logic [NUM_RD_PORTS*XLEN-1:0] rd_data_o,
  output logic [NUM_RD_PORTS-1:0]      rd_valid_o,
  input  logic                         issue_i,
  input  logic [AW-1:0]                issue_rd_i,
  output logic                         issue_full_o,
  input  logic                         wb_i,
  input  logic [AW-1:0]                wb_rd_i,
  input  logic [XLEN-1:0]              wb_data_i,
  input  logic                         flush_i,
  output logic                         stall_o,
  output logic                         sb_err_o
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [XLEN-1:0]         regs_q    [NUM_REGS];
  logic [PEND_W-1:0]       pend_q    [NUM_REGS];
  logic [PEND_W-1:0]       pend_d    [NUM_REGS];
  logic [XLEN-1:0]         rd_data_q [NUM_RD_PORTS];
  logic [XLEN-1:0]         rd_data_d [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0] rd_valid_q;
  logic [NUM_RD_PORTS-1:0] hit;
  logic                    sb_err_q;
  logic                    sb_err_d;
  logic                    wb_wr;
  logic                    issue_acc;

  assign wb_wr        = wb_i && (wb_rd_i != '0);
  // A write-back to the saturated target frees a slot in the same edge, so the issue still fits.
  assign issue_full_o = issue_i && (issue_rd_i != '0) && (pend_q[issue_rd_i] == PEND_MAX)
                        && !(wb_i && (wb_rd_i == issue_rd_i));
  assign issue_acc    = issue_i && !issue_full_o && (issue_rd_i != '0);

  always_comb begin : read_ports
    logic [AW-1:0] addr;
    logic          busy;
    logic          byp;
    stall_o = 1'b0;
    hit     = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      addr = rd_addr_i[p*AW +: AW];
      busy = (pend_q[addr] != '0) && (addr != '0);
`ifdef WB_BYPASS_EN
      byp  = busy && wb_i && (wb_rd_i == addr) && (pend_q[addr] == PEND_ONE)
             && !(issue_i && (issue_rd_i == addr));
`else
      byp  = 1'b0;
`endif
      hit[p]       = rd_en_i[p] && (!busy || byp);
      rd_data_d[p] = rd_data_q[p];
      if (hit[p]) begin
        rd_data_d[p] = byp ? wb_data_i : regs_q[addr];
      end
      if (rd_en_i[p] && !hit[p]) begin
        stall_o = 1'b1;
      end
    end
  end

  // Flush clears first; decrement and an accepted increment on the same register cancel out.
  always_comb begin : pend_next
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_d[r] = flush_i ? '0 : pend_q[r];
      if (!flush_i && wb_i && (wb_rd_i == AW'(r)) && (pend_q[r] != '0)) begin
        pend_d[r] = pend_q[r] - PEND_ONE;
      end
      if (issue_acc && (issue_rd_i == AW'(r))) begin
        pend_d[r] = pend_d[r] + PEND_ONE;
      end
    end
  end

  assign sb_err_d = sb_err_q || (wb_wr && (pend_q[wb_rd_i] == '0) && !flush_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= '0;
      end
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        rd_data_q[p] <= '0;
      end
      rd_valid_q <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      if (wb_wr) begin
        regs_q[wb_rd_i] <= wb_data_i;
      end
      for (int r = 0; r < NUM_REGS; r++) begin
        pend_q[r] <= pend_d[r];
      end
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        rd_data_q[p] <= rd_data_d[p];
      end
      rd_valid_q <= hit;
      sb_err_q   <= sb_err_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_data_o[p*XLEN +: XLEN] = rd_data_q[p];
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign sb_err_o   = sb_err_q;

endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed scenarios plus randomized traffic, checked against a scoreboard model.
module tb_register_file_sb;

  localparam int XLEN = 32;
  localparam int NR   = 32;
  localparam int NP   = 2;
  localparam int AW   = 5;
  localparam int PMAX = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP-1:0]    rd_en;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*XLEN-1:0] rd_data_o;
  logic [NP-1:0]    rd_valid_o;
  logic             issue;
  logic [AW-1:0]    issue_rd;
  logic             issue_full_o;
  logic             wb;
  logic [AW-1:0]    wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             flush;
  logic             stall_o;
  logic             sb_err_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [XLEN-1:0] m_reg  [NR];
  int              m_pend [NR];
  logic [XLEN-1:0] m_rd_data [NP];
  logic [NP-1:0]   m_rd_valid;
  logic            m_err;
  logic            e_stall;
  logic            e_full;
  logic [NP-1:0]   e_hit;
  logic [XLEN-1:0] e_val [NP];

  always #5 clk = ~clk;

  register_file_sb dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .rd_en_i     (rd_en),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .issue_i     (issue),
    .issue_rd_i  (issue_rd),
    .issue_full_o(issue_full_o),
    .wb_i        (wb),
    .wb_rd_i     (wb_rd),
    .wb_data_i   (wb_data),
    .flush_i     (flush),
    .stall_o     (stall_o),
    .sb_err_o    (sb_err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0; issue = 1'b0; issue_rd = '0;
    wb = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic en, input int addr);
    rd_en[p] = en;
    rd_addr[p*AW +: AW] = AW'(addr);
  endtask

  function automatic logic [XLEN-1:0] dut_data(input int p);
    return rd_data_o[p*XLEN +: XLEN];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_reg[r] = '0; m_pend[r] = 0;
    end
    for (int p = 0; p < NP; p++) m_rd_data[p] = '0;
    m_rd_valid = '0; m_err = 1'b0;
  endtask

  // Expected combinational behaviour from the current model state and the driven inputs.
  task automatic model_eval();
    int a;
    logic busy, byp;
    e_stall = 1'b0;
    for (int p = 0; p < NP; p++) begin
      a    = int'(rd_addr[p*AW +: AW]);
      busy = (m_pend[a] != 0) && (a != 0);
      byp  = 1'b0;
`ifdef WB_BYPASS_EN
      byp  = busy && wb && (int'(wb_rd) == a) && (m_pend[a] == 1) && !(issue && int'(issue_rd) == a);
`endif
      e_hit[p] = rd_en[p] && (!busy || byp);
      e_val[p] = byp ? wb_data : m_reg[a];
      if (rd_en[p] && !e_hit[p]) e_stall = 1'b1;
    end
    e_full = issue && (issue_rd != 0) && (m_pend[issue_rd] == PMAX) && !(wb && wb_rd == issue_rd);
  endtask

  task automatic model_commit();
    logic acc;
    for (int p = 0; p < NP; p++) begin
      if (e_hit[p]) m_rd_data[p] = e_val[p];
      m_rd_valid[p] = e_hit[p];
    end
    if (wb && wb_rd != 0 && m_pend[wb_rd] == 0 && !flush) m_err = 1'b1;
    acc = issue && !e_full && (issue_rd != 0);
    if (flush) begin
      for (int r = 0; r < NR; r++) m_pend[r] = 0;
    end else if (wb && wb_rd != 0 && m_pend[wb_rd] > 0) begin
      m_pend[wb_rd]--;
    end
    if (acc) m_pend[issue_rd]++;
    if (wb && wb_rd != 0) m_reg[wb_rd] = wb_data;
  endtask

  // One clock: check combinational outputs, take the edge, check registered outputs.
  task automatic cycle();
    #1;
    model_eval();
    chk("stall", stall_o, e_stall);
    chk("issue_full", issue_full_o, e_full);
    @(posedge clk);
    model_commit();
    #1;
    chk("rd_valid", rd_valid_o, m_rd_valid);
    for (int p = 0; p < NP; p++) chk($sformatf("rd_data%0d", p), dut_data(p), m_rd_data[p]);
    chk("sb_err", sb_err_o, m_err);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", rd_valid_o, 0);
    chk("rst_data", rd_data_o, 0);
    chk("rst_err", sb_err_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_full", issue_full_o, 0);
    rst_n = 1'b1;

    // Reset in the middle of activity
    issue = 1'b1; issue_rd = 5; cycle();
    set_rd(0, 1'b1, 1); cycle();
    chk("pre_rst_valid", rd_valid_o[0], 1'b1);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", rd_valid_o, 0);
    chk("async_rst_data", rd_data_o, 0);
    chk("async_rst_err", sb_err_o, 0);
    model_reset();
    #2 rst_n = 1'b1;
    cycle();
    set_rd(0, 1'b1, 5);
    #1 chk("x5_after_rst_stall", stall_o, 1'b0);
    cycle();
    chk("x5_after_rst_data", dut_data(0), 0);
    chk("x5_after_rst_valid", rd_valid_o[0], 1'b1);

    // Read-after-write hazard
    idle(); issue = 1'b1; issue_rd = 3; cycle();
    idle(); set_rd(0, 1'b1, 3);
    #1 chk("hz_stall", stall_o, 1'b1);
    cycle();
    wb = 1'b1; wb_rd = 3; wb_data = 32'hDEADBEEF;
`ifdef WB_BYPASS_EN
    #1 chk("hz_wb_stall", stall_o, 1'b0);
    cycle();
    chk("hz_byp_valid", rd_valid_o[0], 1'b1);
    chk("hz_byp_data", dut_data(0), 32'hDEADBEEF);
`else
    #1 chk("hz_wb_stall", stall_o, 1'b1);
    cycle();
    chk("hz_wb_valid", rd_valid_o[0], 1'b0);
`endif
    wb = 1'b0;
    cycle();
    chk("hz_after_valid", rd_valid_o[0], 1'b1);
    chk("hz_after_data", dut_data(0), 32'hDEADBEEF);

    // Counter saturation
    idle(); issue = 1'b1; issue_rd = 7;
    repeat (3) cycle();
    #1 chk("sat_full", issue_full_o, 1'b1);
    cycle();
    wb = 1'b1; wb_rd = 7; wb_data = 32'h77;
    #1 chk("sat_full_with_wb", issue_full_o, 1'b0);
    cycle();
    wb = 1'b0;
    #1 chk("sat_still_full", issue_full_o, 1'b1);
    cycle();

    // x0 is hardwired
    idle(); wb = 1'b1; wb_rd = 0; wb_data = 32'h1234; issue = 1'b1; issue_rd = 0;
    set_rd(0, 1'b1, 0); set_rd(1, 1'b1, 0);
    #1 chk("x0_stall", stall_o, 1'b0);
    chk("x0_full", issue_full_o, 1'b0);
    cycle();
    idle(); set_rd(0, 1'b1, 0); set_rd(1, 1'b1, 0);
    cycle();
    chk("x0_data", rd_data_o, 0);
    chk("x0_valid", rd_valid_o, 2'b11);
    chk("x0_err", sb_err_o, 1'b0);

    // Mixed ports: one stalls, the other captures
    idle(); issue = 1'b1; issue_rd = 6; cycle();
    idle(); issue = 1'b1; issue_rd = 4; wb = 1'b1; wb_rd = 6; wb_data = 32'h55; cycle();
    idle(); set_rd(0, 1'b1, 4); set_rd(1, 1'b1, 6);
    #1 chk("mix_stall", stall_o, 1'b1);
    cycle();
    chk("mix_valid", rd_valid_o, 2'b10);
    chk("mix_data1", dut_data(1), 32'h55);

    // Flush, then an unexpected write-back
    idle(); issue = 1'b1; issue_rd = 9; cycle(); cycle();
    idle(); flush = 1'b1; cycle();
    idle(); set_rd(0, 1'b1, 9);
    #1 chk("flush_stall", stall_o, 1'b0);
    cycle();
    chk("flush_valid", rd_valid_o[0], 1'b1);
    idle(); wb = 1'b1; wb_rd = 9; wb_data = 32'hA5A5A5A5; cycle();
    chk("err_set", sb_err_o, 1'b1);
    idle(); set_rd(0, 1'b1, 9); cycle();
    chk("err_sticky", sb_err_o, 1'b1);
    chk("err_wb_data", dut_data(0), 32'hA5A5A5A5);

    // Randomized traffic on a small register window so hazards are frequent
    idle();
    #2 rst_n = 1'b0;
    #1 model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      rd_en    = NP'($urandom_range(3, 0));
      for (int p = 0; p < NP; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(7, 0));
      issue    = ($urandom_range(1, 0) == 1);
      issue_rd = AW'($urandom_range(7, 0));
      wb       = ($urandom_range(9, 0) < 4);
      wb_rd    = AW'($urandom_range(7, 0));
      wb_data  = $urandom;
      flush    = ($urandom_range(19, 0) == 0);
      cycle();
      if (i == 300) begin
        idle();
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk("rand_rst_err", sb_err_o, 1'b0);
        #1 rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
